// File: rtl/cornice_mobile.sv
// cornice_mobile: rectangle/frame sprite that bounces around the screen once per frame
// and reports a registered, one-cycle-latency pixel hit. Optional blink: define BLINK_EN.
module cornice_mobile #(
    parameter int W            = 11,
    parameter int LARGHEZZA    = 100,
    parameter int ALTEZZA      = 100,
    parameter int SPESSORE     = 3,
    parameter int VEL_X        = 4,
    parameter int VEL_Y        = 2,
    parameter int SCHERMO_X    = 640,
    parameter int SCHERMO_Y    = 480,
    parameter int X_INIT       = 0,
    parameter int Y_INIT       = 0,
    parameter int PERIODO_LAMP = 30
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         frame_tick_i,
    input  logic         abilita_i,
    input  logic         modo_i,
    input  logic [W-1:0] x_controllo_i,
    input  logic [W-1:0] y_controllo_i,
    output logic [W-1:0] x_pos_o,
    output logic [W-1:0] y_pos_o,
    output logic         conferma_o,
    output logic         esterno_o,
    output logic         interno_o
);

    // Per-axis direction state (X and Y are independent)
    // state   | meaning
    // DIR_POS | position grows on each enabled frame tick
    // DIR_NEG | position shrinks on each enabled frame tick
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    localparam int WE = W + 1;

    localparam logic [W:0]   LARG_E = WE'(LARGHEZZA);
    localparam logic [W:0]   ALT_E  = WE'(ALTEZZA);
    localparam logic [W:0]   SPES_E = WE'(SPESSORE);
    localparam logic [W:0]   VX_E   = WE'(VEL_X);
    localparam logic [W:0]   VY_E   = WE'(VEL_Y);
    localparam logic [W:0]   SX_E   = WE'(SCHERMO_X);
    localparam logic [W:0]   SY_E   = WE'(SCHERMO_Y);
    localparam logic [W-1:0] VX_W   = W'(VEL_X);
    localparam logic [W-1:0] VY_W   = W'(VEL_Y);
    localparam logic [W-1:0] X_MAX  = W'(SCHERMO_X - LARGHEZZA);
    localparam logic [W-1:0] Y_MAX  = W'(SCHERMO_Y - ALTEZZA);

    function automatic logic [W:0] ext(input logic [W-1:0] v);
        return {1'b0, v};
    endfunction

    // Returns {new_dir_is_neg, new_pos}. Landing exactly on an edge moves without
    // reversing; the reversal happens on the following tick.
    function automatic logic [W:0] step_axis(
        input logic [W-1:0] pos,
        input logic         neg,
        input logic [W:0]   size_e,
        input logic [W:0]   vel_e,
        input logic [W:0]   lim_e,
        input logic [W-1:0] vel_w,
        input logic [W-1:0] top_w
    );
        logic [W:0] r;
        if (!neg) begin
            if (ext(pos) + size_e + vel_e > lim_e) r = {1'b1, top_w};
            else                                   r = {1'b0, pos + vel_w};
        end else begin
            if (pos < vel_w) r = {1'b0, {W{1'b0}}};
            else             r = {1'b1, pos - vel_w};
        end
        return r;
    endfunction

    logic [W-1:0] x_pos_q, x_pos_d;
    logic [W-1:0] y_pos_q, y_pos_d;
    dir_e         dir_x_q, dir_x_d;
    dir_e         dir_y_q, dir_y_d;
    logic         conferma_q, conferma_d;
    logic         esterno_q, esterno_d;
    logic         interno_q, interno_d;
    logic         visibile;

    logic [W:0] passo_x, passo_y;

    always_comb begin
        passo_x = step_axis(x_pos_q, dir_x_q == DIR_NEG, LARG_E, VX_E, SX_E, VX_W, X_MAX);
        passo_y = step_axis(y_pos_q, dir_y_q == DIR_NEG, ALT_E, VY_E, SY_E, VY_W, Y_MAX);
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (frame_tick_i && abilita_i) begin
            x_pos_d = passo_x[W-1:0];
            y_pos_d = passo_y[W-1:0];
            dir_x_d = dir_e'(passo_x[W]);
            dir_y_d = dir_e'(passo_y[W]);
        end
    end

    // Hit test against the position held this cycle; all sums are W+1 bits wide.
    logic [W:0] xp_e, yp_e, xc_e, yc_e;
    logic       out_x, out_y, in_x, in_y;

    always_comb begin
        xp_e  = ext(x_pos_q);
        yp_e  = ext(y_pos_q);
        xc_e  = ext(x_controllo_i);
        yc_e  = ext(y_controllo_i);
        out_x = (xp_e < xc_e) && (xc_e < xp_e + LARG_E);
        out_y = (yp_e < yc_e) && (yc_e < yp_e + ALT_E);
        in_x  = (xp_e + SPES_E < xc_e) && (xc_e < xp_e + LARG_E - SPES_E);
        in_y  = (yp_e + SPES_E < yc_e) && (yc_e < yp_e + ALT_E - SPES_E);
        esterno_d  = out_x && out_y;
        interno_d  = in_x && in_y;
        conferma_d = visibile && esterno_d && !(modo_i && interno_d);
    end

`ifdef BLINK_EN
    localparam int CW = (PERIODO_LAMP > 1) ? $clog2(PERIODO_LAMP) : 1;
    localparam logic [CW-1:0] LAMP_TOP = CW'(PERIODO_LAMP - 1);

    logic [CW-1:0] lamp_cnt_q;
    logic          lamp_vis_q;

    // Blink runs off every frame tick, even while motion is disabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lamp_cnt_q <= '0;
            lamp_vis_q <= 1'b1;
        end else if (frame_tick_i) begin
            if (lamp_cnt_q == LAMP_TOP) begin
                lamp_cnt_q <= '0;
                lamp_vis_q <= !lamp_vis_q;
            end else begin
                lamp_cnt_q <= lamp_cnt_q + 1'b1;
            end
        end
    end

    assign visibile = lamp_vis_q;
`else
    assign visibile = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_pos_q    <= W'(X_INIT);
            y_pos_q    <= W'(Y_INIT);
            dir_x_q    <= DIR_POS;
            dir_y_q    <= DIR_POS;
            conferma_q <= 1'b0;
            esterno_q  <= 1'b0;
            interno_q  <= 1'b0;
        end else begin
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            conferma_q <= conferma_d;
            esterno_q  <= esterno_d;
            interno_q  <= interno_d;
        end
    end

    assign x_pos_o    = x_pos_q;
    assign y_pos_o    = y_pos_q;
    assign conferma_o = conferma_q;
    assign esterno_o  = esterno_q;
    assign interno_o  = interno_q;

endmodule

// File: doc/cornice_mobile.md
Name: cornice_mobile

Overview:
Parametrised rectangle/frame sprite for the VGA pixel pipeline. It holds its own top-left position in registers and moves it by a fixed velocity once per video frame, bouncing off the screen edges. It hit-tests the current scan coordinate against either a filled rectangle or a hollow frame of configurable thickness. It returns a registered, one-cycle-latency CONFERMA for the colour mux.

Parameters:
W, 11, coordinate width in bits
LARGHEZZA, 100, outer width in pixels
ALTEZZA, 100, outer height in pixels
SPESSORE, 3, frame thickness in pixels per side; must satisfy 2*SPESSORE < min(LARGHEZZA, ALTEZZA)
VEL_X, 4, horizontal step per frame in pixels
VEL_Y, 2, vertical step per frame in pixels
SCHERMO_X, 640, visible width in pixels
SCHERMO_Y, 480, visible height in pixels
X_INIT, 0, reset X position
Y_INIT, 0, reset Y position
PERIODO_LAMP, 30, frames per blink half-period (only with BLINK_EN)

Ports:
CLK  in  1  pixel clock
RST  in  1  synchronous, active-high reset
FRAME_TICK  in  1  one-cycle pulse per frame at start of vertical blanking
ABILITA  in  1  1 = motion enabled
MODO  in  1  0 = filled rectangle, 1 = hollow frame
X_CONTROLLO  in  W  current scan X
Y_CONTROLLO  in  W  current scan Y
X_POS  out  W  registered top-left X
Y_POS  out  W  registered top-left Y
CONFERMA  out  1  registered pixel-inside result
ESTERNO  out  1  registered outer-rectangle hit
INTERNO  out  1  registered inner-rectangle hit

Behaviour:
- Reset is synchronous on the CLK edge with RST=1:
  - X_POS=X_INIT, Y_POS=Y_INIT.
  - Direction state DIR_X=+, DIR_Y=+.
  - CONFERMA, ESTERNO and INTERNO are 0.
  - Blink counter is 0, visible.
  - RST overrides FRAME_TICK in the same cycle.
- Direction state per axis: two states, POS (+) and NEG (−). X and Y are independent.
- Update happens only when FRAME_TICK=1 and ABILITA=1. Otherwise position and direction hold.
- X update, all arithmetic in W+1 bits, no wrap:
  - DIR POS: if X_POS+LARGHEZZA+VEL_X > SCHERMO_X, then X_POS←SCHERMO_X−LARGHEZZA and DIR←NEG. Else X_POS←X_POS+VEL_X.
  - DIR NEG: if X_POS < VEL_X, then X_POS←0 and DIR←POS. Else X_POS←X_POS−VEL_X.
  - Exactly reaching an edge (sum == SCHERMO_X, or X_POS == VEL_X) moves without reversing. Reversal happens on the next tick.
- Y update: identical to X, using ALTEZZA, VEL_Y and SCHERMO_Y.
- Hit test uses the X_POS/Y_POS value present in the same cycle as the coordinate. The result registers on the next edge, so latency is 1 cycle.
  - Outer hit: X_POS < X_CONTROLLO < X_POS+LARGHEZZA and Y_POS < Y_CONTROLLO < Y_POS+ALTEZZA. Bounds are strict; sums are W+1 bits.
  - Inner hit: X_POS+SPESSORE < X_CONTROLLO < X_POS+LARGHEZZA−SPESSORE, with the same form in Y.
  - CONFERMA = ESTERNO when MODO=0; CONFERMA = ESTERNO & !INTERNO when MODO=1.
  - ESTERNO and INTERNO are always reported regardless of MODO.
- MODO, ABILITA and coordinates may change on any cycle. A MODO change takes effect on the next registered result.
- Toggling ABILITA mid-frame only gates the next FRAME_TICK. Direction state is preserved while disabled.

Optional Feature:
BLINK_EN
- Defined:
  - A frame counter of width ceil(log2(PERIODO_LAMP)) plus a visibility flag.
  - On each FRAME_TICK (independent of ABILITA) the counter increments. At PERIODO_LAMP−1 it returns to 0 and the flag toggles.
  - While the flag is 0, CONFERMA is registered as 0. ESTERNO and INTERNO are unaffected.
  - Reset leaves the block visible.
- Not defined: no counter, always visible.

Test Plan:
- Filled hit test: RST for 2 cycles, MODO=0, coordinates (50,50) → one cycle later CONFERMA=1, ESTERNO=1, INTERNO=1. Coordinates (0,50) and (100,50) → CONFERMA=0 (strict bounds).
- Frame mode: MODO=1, position (0,0), coordinates (2,50) → CONFERMA=1. Coordinates (4,50) → CONFERMA=0, INTERNO=1. Coordinates (3,50) → CONFERMA=1.
- Motion: ABILITA=1, 10 FRAME_TICKs → X_POS=40, Y_POS=20. With ABILITA=0, further ticks leave the position unchanged.
- Right bounce: tick until X_POS=540 (135 ticks) → next tick X_POS stays 540 and DIR_X=NEG → following tick X_POS=536.
- Left bounce: DIR_X=NEG with X_POS=2 → tick gives X_POS=0, DIR_X=POS → next tick X_POS=4. Bottom bounce (Y_POS=380) is checked the same way.
- Reset mid-motion: RST asserted together with FRAME_TICK at X_POS=200 → X_POS=0, directions POS, outputs 0. With BLINK_EN: after 30 ticks CONFERMA is forced to 0 at an inside pixel while ESTERNO=1, and it returns after 30 more ticks.
